// File: rtl/operand_seq_pkg.sv
// Shared types and default sizing for the operand sequencer.
package operand_seq_pkg;

  localparam int unsigned DefaultW     = 5;
  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [DefaultW-1:0] a;
    logic [DefaultW-1:0] b;
    logic [DefaultW-1:0] c;
    logic [DefaultW-1:0] d;
    logic [DefaultW-1:0] e;
  } vec_t;

endpackage

// File: rtl/seq_table.sv
// Operand vector register file: one synchronous write port, one combinational read port.
module seq_table
  import operand_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = DefaultDepth,
  parameter type         entry_t = vec_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  // No reset: contents survive a sequencer reset.
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/operand_sequencer.sv
// Streams len stored operand vectors to a ready/valid pipeline input.
// Optional OPERAND_SEQUENCER_LOOP_EN adds a loop input that replays the table without ending.
module operand_sequencer
  import operand_seq_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_a,
  input  logic [W-1:0]  wr_b,
  input  logic [W-1:0]  wr_c,
  input  logic [W-1:0]  wr_d,
  input  logic [W-1:0]  wr_e,
  input  logic [LW-1:0] len,
  input  logic          start,
`ifdef OPERAND_SEQUENCER_LOOP_EN
  input  logic          loop,
`endif
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [W-1:0]  c,
  output logic [W-1:0]  d,
  output logic [W-1:0]  e,
  output logic          busy,
  output logic          done
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] e;
  } op_vec_t;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  op_vec_t       wr_vec, rd_vec;
  logic          loop_en, len_ok, xfer, last;

`ifdef OPERAND_SEQUENCER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign wr_vec = '{a: wr_a, b: wr_b, c: wr_c, d: wr_d, e: wr_e};

  seq_table #(
    .DEPTH  (DEPTH),
    .entry_t(op_vec_t)
  ) u_table (
    .clk  (clk),
    .we   (wr_en && (state_q == StIdle)),
    .waddr(wr_addr),
    .wdata(wr_vec),
    .raddr(idx_q),
    .rdata(rd_vec)
  );

  assign len_ok    = (len != '0) && (len <= LW'(DEPTH));
  assign out_valid = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign xfer      = out_valid && out_ready;
  assign last      = ({1'b0, idx_q} == (len_q - LW'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    case (state_q)
      StIdle: begin
        if (start && len_ok) begin
          state_d = StRun;
          len_d   = len;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (xfer) begin
          if (!last) begin
            idx_d = idx_q + AW'(1);
          end else if (loop_en) begin
            idx_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    e = '0;
    if (out_valid) begin
      a = rd_vec.a;
      b = rd_vec.b;
      c = rd_vec.c;
      d = rd_vec.d;
      e = rd_vec.e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter W, default 5, width of each operand (a..e).
REQ-002 Parameter DEPTH, default 16, number of vector slots in the table; a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 wr_en  input  1  table write strobe, accepted only in IDLE.
REQ-006 wr_addr  input  $clog2(DEPTH)  table slot to write.
REQ-007 wr_a, wr_b, wr_c, wr_d, wr_e  input  W each  operand vector to store.
REQ-008 len  input  $clog2(DEPTH)+1  number of vectors to stream, 1..DEPTH; sampled at start.
REQ-009 start  input  1  single-cycle pulse that begins streaming from slot 0.
REQ-010 out_ready  input  1  downstream pipeline accepts the current vector.
REQ-011 out_valid  output  1  a, b, c, d, e hold a valid vector.
REQ-012 a, b, c, d, e  output  W each  operand vector driven into the pipeline.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse after the last vector is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on start=1 when len is between 1 and DEPTH inclusive; the block SHALL latch len and clear the index.
- start with len=0 or len>DEPTH SHALL be ignored; the FSM stays in IDLE.
REQ-017 The table write SHALL take effect at the edge where wr_en=1 in IDLE; wr_en in RUN or DONE SHALL be ignored.
REQ-018 In RUN, out_valid=1 and a..e SHALL equal table[index] combinationally from registered index.
- Latency from start to first out_valid: 1 cycle.
REQ-019 A transfer occurs when out_valid and out_ready are both 1 at a rising edge.
- On a transfer, index SHALL increment.
- Without a transfer, index and a..e SHALL hold (stall).
REQ-020 On the transfer of index len-1, the FSM SHALL go RUN -> DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 out_valid SHALL be 0 in IDLE and DONE; in those states a..e SHALL be 0.
REQ-022 start in RUN or DONE SHALL be ignored.
REQ-023 With out_ready held at 1, exactly len vectors SHALL stream on consecutive cycles.

Reset
REQ-024 rst=0 at a rising edge SHALL force:
- state to IDLE and index to 0;
- out_valid=0, busy=0, done=0 and a..e=0.
REQ-025 Reset SHALL NOT clear the table contents.
REQ-026 Reset in the middle of RUN SHALL abort the stream with no done pulse.

Configuration
REQ-027 With macro OPERAND_SEQUENCER_LOOP_EN defined, a one-bit input loop SHALL exist.
- When loop=1 at the last transfer, the block SHALL wrap index to 0 and stay in RUN with no done pulse.
- When loop=0 at the last transfer, the block SHALL take the normal RUN -> DONE path.
REQ-028 Without OPERAND_SEQUENCER_LOOP_EN, the loop port SHALL NOT exist and streaming SHALL always end in DONE.

Structure
REQ-029 Package operand_seq_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- a packed struct vec_t with fields a..e of W bits;
- the default constants W=5 and DEPTH=16.
REQ-030 Sub-module seq_table SHALL be a DEPTH x vec_t register file with one synchronous write port and one combinational read port; it has no reset.

Verification
REQ-031 Load slots 0..4 with {6,7,8,3,10}, {4,8,7,3,1}, {1,9,6,3,5}, {8,7,3,7,2}, {6,10,3,3,10}; len=5; start; out_ready=1 -> the five vectors appear in order on 5 consecutive cycles, then done=1 for exactly one cycle.
REQ-032 Same load; toggle out_ready 1,0,0,1,... -> each vector holds while out_ready=0; exactly 5 transfers occur with no skips or duplicates.
REQ-033 Apply start with len=0, and separately with len=DEPTH+1 -> busy stays 0 and out_valid stays 0.
REQ-034 Assert rst=0 after 2 transfers of a len=5 run -> all outputs are 0 on the next cycle with no done pulse; a new start replays from slot 0 with the table intact.
REQ-035 Apply wr_en during RUN targeting slot 3 -> slot 3 still emits its old value.
REQ-036 With OPERAND_SEQUENCER_LOOP_EN, loop=1 and len=2 -> the vectors repeat 0,1,0,1,...; dropping loop to 0 ends the stream after the next slot-1 transfer with a done pulse.
